// File: rtl/lru_way_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lru_way_tracker_pkg
//  Description : Shared constants and the log2 helper used by the cache top,
//                the hit decoder and the LRU way tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package lru_way_tracker_pkg;

    // Default cache geometry shared with the cache top
    localparam int c_default_num_sets = 64;
    localparam int c_default_num_ways = 4;

    // Ceiling log2; exact for the power-of-two geometries used here
    function automatic int log2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lru_age_update.sv
`default_nettype none
// ============================================================================
//  Module      : lru_age_update
//  Description : Combinational true-LRU age update for one set. The accessed
//                way becomes age 0; every way younger than it ages by one;
//                older ways keep their age, so the ages stay a permutation.
//  Revision    : 1.0 - initial release
// ============================================================================
module lru_age_update #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_BITS = 2
) (
    input  logic [NUM_WAYS*WAY_BITS-1:0] i_ages,
    input  logic [WAY_BITS-1:0]          i_access_way,
    output logic [NUM_WAYS*WAY_BITS-1:0] o_ages
);

    logic [WAY_BITS-1:0] w_accessed_age;

    // Look up the current age of the accessed way
    always_comb begin
        w_accessed_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_access_way == WAY_BITS'(i)) begin
                w_accessed_age = i_ages[i*WAY_BITS +: WAY_BITS];
            end
        end
    end

    // Promote the accessed way to MRU and shift the younger ways down by one
    always_comb begin
        o_ages = i_ages;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_access_way == WAY_BITS'(i)) begin
                o_ages[i*WAY_BITS +: WAY_BITS] = '0;
            end else if (i_ages[i*WAY_BITS +: WAY_BITS] < w_accessed_age) begin
                o_ages[i*WAY_BITS +: WAY_BITS] = i_ages[i*WAY_BITS +: WAY_BITS] + WAY_BITS'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lru_way_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : lru_way_tracker
//  Description : Per-set true-LRU replacement tracker. Records way accesses
//                per set and returns the LRU way of a queried set one cycle
//                after the request. A set-walking sequencer loads the
//                identity age permutation into every set after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module lru_way_tracker
    import lru_way_tracker_pkg::*;
#(
    parameter  int NUM_SETS = c_default_num_sets,
    parameter  int NUM_WAYS = c_default_num_ways,
    localparam int SET_BITS = log2(NUM_SETS),
    localparam int WAY_BITS = log2(NUM_WAYS)
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic                access_valid,
    input  logic [SET_BITS-1:0] access_set,
    input  logic [WAY_BITS-1:0] access_way,
    input  logic                victim_req,
    input  logic [SET_BITS-1:0] victim_set,
    output logic                victim_valid,
    output logic [WAY_BITS-1:0] victim_way
);

    localparam int                  c_age_bits = NUM_WAYS * WAY_BITS;
    localparam logic [SET_BITS-1:0] c_last_set = SET_BITS'(NUM_SETS - 1);
    localparam logic [WAY_BITS-1:0] c_lru_age  = WAY_BITS'(NUM_WAYS - 1);

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]            r_state;
    logic [SET_BITS-1:0]   r_init_set;
    logic                  r_ready;
    logic                  r_victim_valid;
    logic [WAY_BITS-1:0]   r_victim_way;

    logic [c_age_bits-1:0] r_ages [NUM_SETS];

    logic [c_age_bits-1:0] w_init_ages;
    logic [c_age_bits-1:0] w_access_ages;
    logic [c_age_bits-1:0] w_next_ages;
    logic [c_age_bits-1:0] w_query_ages;
    logic [WAY_BITS-1:0]   w_victim_way;
    logic                  w_wr_en;
    logic [SET_BITS-1:0]   w_wr_set;
    logic [c_age_bits-1:0] w_wr_ages;

    // Identity permutation written by the init walker: way i gets age i
    genvar g;
    generate
        for (g = 0; g < NUM_WAYS; g++) begin : g_init_ages
            assign w_init_ages[g*WAY_BITS +: WAY_BITS] = WAY_BITS'(g);
        end
    endgenerate

    assign w_access_ages = r_ages[access_set];
    assign w_query_ages  = r_ages[victim_set];

    lru_age_update #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_age_update (
        .i_ages       (w_access_ages),
        .i_access_way (access_way),
        .o_ages       (w_next_ages)
    );

    // Victim search on pre-update ages: the way holding the oldest age
    always_comb begin
        w_victim_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (w_query_ages[i*WAY_BITS +: WAY_BITS] == c_lru_age) begin
                w_victim_way = WAY_BITS'(i);
            end
        end
    end

    // Single write port: init walker during INIT, access update during RUN
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_set  = r_init_set;
        w_wr_ages = w_init_ages;
        if (!reset) begin
            if (r_state == c_st_init) begin
                w_wr_en = 1'b1;
            end else if (access_valid) begin
                w_wr_en   = 1'b1;
                w_wr_set  = access_set;
                w_wr_ages = w_next_ages;
            end
        end
    end

    // Age storage, no reset: contents are rebuilt by the init walker
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_ages[w_wr_set] <= w_wr_ages;
        end
    end

    // Init/run sequencer and registered victim output
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_st_init;
            r_init_set     <= '0;
            r_ready        <= 1'b0;
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
        end else begin
            case (r_state)
                c_st_init: begin
                    r_victim_valid <= 1'b0;
                    r_init_set     <= r_init_set + SET_BITS'(1);
                    if (r_init_set == c_last_set) begin
                        r_state <= c_st_run;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_victim_valid <= victim_req;
                    if (victim_req) begin
                        r_victim_way <= w_victim_way;
                    end
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;

endmodule
`default_nettype wire

// File: tb/tb_lru_way_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lru_way_tracker
//  Description : Self-checking bench for lru_way_tracker (8 sets, 4 ways).
//                Directed vectors from a table, hand-written reset sequences
//                and a random stream checked against a recency-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lru_way_tracker;

    localparam int c_sets = 8;
    localparam int c_ways = 4;

    logic       clock;
    logic       reset;
    logic       ready;
    logic       access_valid;
    logic [2:0] access_set;
    logic [1:0] access_way;
    logic       victim_req;
    logic [2:0] victim_set;
    logic       victim_valid;
    logic [1:0] victim_way;

    lru_way_tracker #(
        .NUM_SETS (c_sets),
        .NUM_WAYS (c_ways)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .access_valid (access_valid),
        .access_set   (access_set),
        .access_way   (access_way),
        .victim_req   (victim_req),
        .victim_set   (victim_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       av;
        logic [2:0] aset;
        logic [1:0] away;
        logic       vr;
        logic [2:0] vset;
        int         exp_victim;
    } vec_t;

    int   checks;
    int   failures;
    int   exp_q[$];
    int   m_order [c_sets][c_ways];
    bit   m_ready;
    int   m_cnt;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [2:0] aset, input logic [1:0] away,
                                input logic vr, input logic [2:0] vset, input int exp_victim);
        vec_t v;
        v.av = av; v.aset = aset; v.away = away;
        v.vr = vr; v.vset = vset; v.exp_victim = exp_victim;
        return v;
    endfunction

    // Recency list model: m_order[s][0] is MRU, m_order[s][c_ways-1] is LRU
    task automatic model_access(input int s, input int w);
        int p;
        p = 0;
        for (int k = 0; k < c_ways; k++) if (m_order[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
        m_order[s][0] = w;
    endtask

    // One clock cycle: drive, push expectation, take edge, update model, check
    task automatic tick(input logic rst_v, input logic av, input logic [2:0] aset,
                        input logic [1:0] away, input logic vr, input logic [2:0] vset,
                        input int exp_victim);
        int exp_valid;
        reset        = rst_v;
        access_valid = av;
        access_set   = aset;
        access_way   = away;
        victim_req   = vr;
        victim_set   = vset;
        if (vr && m_ready && !rst_v)
            exp_q.push_back(exp_victim >= 0 ? exp_victim : m_order[vset][c_ways-1]);
        @(posedge clock);
        #1;
        if (rst_v) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            for (int k = 0; k < c_ways; k++) m_order[m_cnt][k] = k;
            if (m_cnt == c_sets - 1) m_ready = 1'b1;
            m_cnt = (m_cnt + 1) % c_sets;
        end else if (av) begin
            model_access(int'(aset), int'(away));
        end
        chk("ready", int'(ready), int'(m_ready));
        exp_valid = (exp_q.size() != 0) ? 1 : 0;
        chk("victim_valid", int'(victim_valid), exp_valid);
        if (exp_valid != 0) begin
            int e;
            e = exp_q.pop_front();
            if (victim_valid) chk("victim_way", int'(victim_way), e);
        end
        if (rst_v) chk("reset_victim_way", int'(victim_way), 0);
    endtask

    initial begin
        checks = 0; failures = 0; m_ready = 1'b0; m_cnt = 0;
        for (int s = 0; s < c_sets; s++)
            for (int k = 0; k < c_ways; k++) m_order[s][k] = k;
        reset = 1'b1; access_valid = 1'b0; access_set = '0; access_way = '0;
        victim_req = 1'b0; victim_set = '0;

        // Directed table: initial victims, access sequences, same-cycle cases
        for (int s = 0; s < c_sets; s++) vecs.push_back(mk(0, 0, 0, 1, 3'(s), 3));
        vecs.push_back(mk(1, 2, 3, 0, 0, -1));
        vecs.push_back(mk(1, 2, 1, 0, 0, -1));
        vecs.push_back(mk(1, 2, 0, 0, 0, -1));
        vecs.push_back(mk(1, 2, 2, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 3));
        vecs.push_back(mk(1, 2, 3, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1));
        vecs.push_back(mk(1, 5, 0, 0, 0, -1));
        vecs.push_back(mk(1, 5, 0, 1, 5, 3));
        vecs.push_back(mk(1, 5, 0, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0, 1, 5, 3));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 3));
        vecs.push_back(mk(1, 4, 3, 1, 4, 3));
        vecs.push_back(mk(0, 0, 0, 1, 4, 2));
        vecs.push_back(mk(1, 6, 3, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 1, 6, 2));

        // Reset values, then a reset in the middle of INIT
        tick(1, 0, 0, 0, 0, 0, -1);
        tick(1, 0, 0, 0, 0, 0, -1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, -1);
        tick(1, 0, 0, 0, 0, 0, -1);
        for (int i = 0; i < c_sets; i++) tick(0, 0, 0, 0, 0, 0, -1);
        chk("ready_after_init", int'(ready), 1);

        foreach (vecs[i])
            tick(0, vecs[i].av, vecs[i].aset, vecs[i].away, vecs[i].vr, vecs[i].vset,
                 vecs[i].exp_victim);
        tick(0, 0, 0, 0, 0, 0, -1);

        // Reset in RUN after touching sets 0 and 7; inputs active during INIT
        tick(0, 1, 0, 3, 0, 0, -1);
        tick(0, 1, 7, 3, 1, 0, 2);
        tick(0, 0, 0, 0, 1, 7, 2);
        tick(1, 1, 1, 3, 1, 0, -1);
        for (int i = 0; i < c_sets; i++) tick(0, 1, 0, 3, 1, 3'(i), -1);
        for (int s = 0; s < c_sets; s++) tick(0, 0, 0, 0, 1, 3'(s), 3);
        tick(0, 0, 0, 0, 0, 0, -1);

        // Random stream against the model
        for (int i = 0; i < 2000; i++)
            tick(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), -1);
        tick(0, 0, 0, 0, 0, 0, -1);
        chk("queue_drained", exp_q.size(), 0);

        // Stored ages must equal the model's recency positions
        for (int s = 0; s < c_sets; s++) begin
            logic [7:0] word;
            word = dut.r_ages[s];
            for (int w = 0; w < c_ways; w++) begin
                int pos;
                pos = 0;
                for (int k = 0; k < c_ways; k++) if (m_order[s][k] == w) pos = k;
                chk("final_age", int'(word[w*2 +: 2]), pos);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
